// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up.
// Optional macro RV_MULDIV_EARLY_EN ends a multiply once the remaining multiplier bits are zero.
module rv_muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            rd_valid,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_CORR = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              negQ_q, negQ_d;
    logic              negR_q, negR_d;

    logic              aSigned, bSigned, aNeg, bNeg;
    logic [XLEN-1:0]   absA, absB;
    logic              divZero, divOvf;
    logic [XLEN:0]     remShift;
    logic              remGeq;
    logic [XLEN-1:0]   remSub;
    logic [XLEN-1:0]   mplierShift;
    logic              lastStep, earlyOut;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient, remainder;

    // Operand signedness from funct3, then magnitudes fed to the unsigned datapath.
    assign aSigned = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign bSigned = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign aNeg    = aSigned & op_a[XLEN-1];
    assign bNeg    = bSigned & op_b[XLEN-1];
    assign absA    = aNeg ? -op_a : op_a;
    assign absB    = bNeg ? -op_b : op_b;
    assign divZero = funct3[2] && (op_b == '0);
    assign divOvf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // The low half of acc holds the partial remainder; mplier shifts the dividend out and quotient in.
    assign remShift    = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    assign remGeq      = remShift >= {1'b0, mcand_q[XLEN-1:0]};
    assign remSub      = remShift[XLEN-1:0] - mcand_q[XLEN-1:0];
    assign mplierShift = mplier_q >> 1;
    assign lastStep    = (cnt_q == CNT_W'(XLEN-1));

`ifdef RV_MULDIV_EARLY_EN
    assign earlyOut = (mplierShift == '0);
`else
    assign earlyOut = 1'b0;
`endif

    assign product   = negQ_q ? -acc_q : acc_q;
    assign quotient  = negQ_q ? -mplier_q : mplier_q;
    assign remainder = negR_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    funct3_d = funct3;
                    rd_d     = rd_in;
                    cnt_d    = '0;
                    acc_d    = '0;
                    negQ_d   = aNeg ^ bNeg;
                    negR_d   = aNeg;
                    if (funct3[2]) begin
                        mcand_d  = {{XLEN{1'b0}}, absB};
                        mplier_d = absA;
                        state_d  = S_DIV;
                        // Special cases preload the final quotient/remainder and skip the iterations.
                        if (divZero) begin
                            mplier_d = '1;
                            acc_d    = {{XLEN{1'b0}}, op_a};
                            negQ_d   = 1'b0;
                            negR_d   = 1'b0;
                            state_d  = S_CORR;
                        end else if (divOvf) begin
                            mplier_d = op_a;
                            negQ_d   = 1'b0;
                            negR_d   = 1'b0;
                            state_d  = S_CORR;
                        end
                    end else begin
                        mcand_d  = {{XLEN{1'b0}}, absA};
                        mplier_d = absB;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplierShift;
                cnt_d    = cnt_q + 1'b1;
                if (lastStep || earlyOut) state_d = S_CORR;
            end
            S_DIV: begin
                acc_d    = {{XLEN{1'b0}}, remGeq ? remSub : remShift[XLEN-1:0]};
                mplier_d = {mplier_q[XLEN-2:0], remGeq};
                cnt_d    = cnt_q + 1'b1;
                if (lastStep) state_d = S_CORR;
            end
            S_CORR: begin
                if (funct3_q[2])      result_d = funct3_q[1] ? remainder : quotient;
                else if (funct3_q == 3'd0) result_d = product[XLEN-1:0];
                else                  result_d = product[2*XLEN-1:XLEN];
                state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign rd_valid = done;
    assign rd_out   = rd_q;
    assign result   = result_q;
endmodule

// File: tb/tb_rv_muldiv_iter.sv
// Directed self-checking bench for rv_muldiv_iter; honours RV_MULDIV_EARLY_EN for multiply latency.
module tb_rv_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, rd_valid;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    int doneCount = 0;
    int lat;
    int dc;

    rv_muldiv_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) doneCount++;

    // Edge after acceptance at which done is seen, for a multiply with multiplier magnitude absB.
    function automatic int mulEdges(input logic [31:0] absB);
`ifdef RV_MULDIV_EARLY_EN
        int steps = 1;
        for (int i = 1; i < 32; i++) if ((absB >> i) != 0) steps = i + 1;
        return steps + 1;
`else
        return 33;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one request at a negedge and returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int edges);
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expRes, input int expEdge);
        int got;
        applyStimulus(f, a, b, rd);
        waitDone(got);
        checkOutput({tag, " latency"}, 32'(got), 32'(expEdge));
        checkOutput({tag, " result"}, result, expRes);
        checkOutput({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        checkOutput({tag, " rd_valid"}, {31'd0, rd_valid}, 32'd1);
        checkOutput({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_cleared"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " busy_cleared"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        #2 rst = 1'b0;
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("reset rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        runOp("mul 7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, mulEdges(32'd6));
        runOp("mulh -1x-1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'd0, mulEdges(32'd1));
        runOp("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, mulEdges(32'hFFFFFFFF));
        runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, mulEdges(32'hFFFFFFFF));

        runOp("div -7/2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, 33);
        runOp("rem -7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFF, 33);
        runOp("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33);
        runOp("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 33);

        runOp("divu by0", 3'd5, 32'd123, 32'd0, 5'd14, 32'hFFFFFFFF, 1);
        runOp("remu by0", 3'd7, 32'd123, 32'd0, 5'd15, 32'd123, 1);
        runOp("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        runOp("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1);

        // A second start during a divide must not disturb the operation in flight.
        dc = doneCount;
        applyStimulus(3'd4, 32'd100, 32'd7, 5'd20);
        repeat (9) @(posedge clk);
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(lat);
        checkOutput("restart latency", 32'(lat), 32'd23);
        checkOutput("restart result", result, 32'd14);
        checkOutput("restart rd_out", {27'd0, rd_out}, 32'd20);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("restart single done", 32'(doneCount), 32'(dc + 1));
        checkOutput("restart idle", {31'd0, busy}, 32'd0);

        // flush wins over start while idle.
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checkOutput("flush prio busy", {31'd0, busy}, 32'd0);

        // Flush a long multiply at cycle 12.
        dc = doneCount;
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush busy", {31'd0, busy}, 32'd0);
        checkOutput("flush done", {31'd0, done}, 32'd0);
        checkOutput("flush result kept", result, 32'd14);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("flush no done", 32'(doneCount), 32'(dc));

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
        repeat (11) @(posedge clk);
        @(negedge clk);
        dc = doneCount;
        rst = 1'b0;
        #1;
        checkOutput("async busy", {31'd0, busy}, 32'd0);
        checkOutput("async done", {31'd0, done}, 32'd0);
        checkOutput("async rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("async rd_out", {27'd0, rd_out}, 32'd0);
        checkOutput("async result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("async no done", 32'(doneCount), 32'(dc));

        runOp("mul 3x3", 3'd0, 32'd3, 32'd3, 5'd4, 32'd9, mulEdges(32'd3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
